axis_shutdown_sequencer: RTL and testbench
==========================================

Name: axis_shutdown_sequencer

Overview:
- Orders shutdown and bring-up of a chain of N axis_shutdown_w instances along one AXI-Stream path.
- Shutdown is issued upstream-first, channel 0 to N-1, so each stage drains before the stage after it stops.
- Bring-up runs in reverse order, N-1 down to 0, so downstream stages accept data before upstream stages release it.
- Each step is bounded by a timeout, and unresponsive channels are recorded in an error mask for software.

Parameters:
- C_NUM_CHANNELS, 4, number of controlled shutdown channels (1..32); channel 0 is the most upstream.
- C_TIMEOUT_CYCLES, 1024, maximum wait per step in clk cycles; 0 disables the timeout.
- C_TIMEOUT_WIDTH, 16, width of the step counter; must satisfy C_TIMEOUT_CYCLES < 2^C_TIMEOUT_WIDTH.

Ports:
- clk  in  1  single clock; all logic is synchronous to it.
- rst  in  1  synchronous, active-high reset.
- cmd_shutdown  in  1  level command: 1 = path shut down, 0 = path running.
- chan_req  out  C_NUM_CHANNELS  per-channel shutdown_req, one bit to each axis_shutdown_w.
- chan_ack  in  C_NUM_CHANNELS  per-channel shutdown_ack; may be CDC-delayed by any number of cycles.
- status_up  out  1  high in state UP.
- status_down  out  1  high in state DOWN.
- busy  out  1  high in SHUTTING or STARTING.
- cur_chan  out  $clog2(C_NUM_CHANNELS) or 1 bit, whichever is larger  index of the channel in the current step.
- err_mask  out  C_NUM_CHANNELS  sticky per-channel timeout flags.

Behaviour:
- All outputs are registered.
- Reset values: state UP, chan_req = 0, cur_chan = 0, err_mask = 0, step counter = 0, status_up = 1, status_down = 0, busy = 0.
- Reset is obeyed in every state. It drops all chan_req bits on the next edge, with no orderly release.
- Internal index i drives cur_chan. A step counter cnt clears on every step entry and increments by 1 each cycle while the step waits.

State UP:
- When cmd_shutdown = 1 is sampled: i <= 0, err_mask <= 0, state <= SHUTTING, chan_req[0] <= 1.
- chan_req[0] is therefore visible one cycle after cmd is sampled high.

State SHUTTING:
- chan_req bits 0..i are 1; all others are 0.
- The step completes on the first cycle where chan_ack[i] = 1 is sampled.
- The step also completes when C_TIMEOUT_CYCLES != 0 and cnt == C_TIMEOUT_CYCLES-1 with chan_ack[i] = 0. In that case err_mask[i] <= 1.
- On completion, in priority order:
  - if cmd_shutdown = 0: state <= STARTING with i unchanged, and chan_req[i] <= 0 (reversal).
  - else if i == N-1: state <= DOWN.
  - else: i <= i+1 and chan_req[i+1] <= 1.
- If chan_ack[i] is already 1 on entry, the step completes in its first cycle, so consecutive req rises are at least 1 cycle apart.

State DOWN:
- All chan_req bits are 1.
- When cmd_shutdown = 0 is sampled: i <= N-1, err_mask <= 0, state <= STARTING, chan_req[N-1] <= 0.

State STARTING:
- chan_req bits 0..i-1 are 1; bit i and above are 0.
- The step completes on the first cycle where chan_ack[i] = 0 is sampled, or on timeout with the same rule as SHUTTING (sets err_mask[i]).
- On completion, in priority order:
  - if cmd_shutdown = 1: state <= SHUTTING with i unchanged, and chan_req[i] <= 1.
  - else if i == 0: state <= UP.
  - else: i <= i-1 and chan_req[i-1] <= 0.

Boundary rules:
- cmd_shutdown changes mid-step: the change is acted on only at step completion, never by aborting a step.
- A timed-out step still advances the sequence; the timed-out channel's req keeps its commanded value.
- chan_ack bits for channels other than i are ignored.
- err_mask keeps its value until the next sequence starts from UP or DOWN. A reversal does not clear it.
- C_NUM_CHANNELS = 1: i stays 0, and cur_chan is 1 bit wide, tied to 0.

Test Plan:
- N=4; each ack follows its req after 3 cycles; cmd 0->1 -> chan_req rises in order 0,1,2,3, each rise 4 cycles after the previous one; DOWN reached; busy=0, status_down=1, err_mask=0.
- From DOWN, cmd 1->0 with 3-cycle ack lag -> chan_req falls in order 3,2,1,0; UP reached; status_up=1.
- C_TIMEOUT_CYCLES=8, chan_ack[2] stuck at 0 during shutdown -> step 2 lasts exactly 8 cycles; err_mask=4'b0100; sequence still reaches DOWN with chan_req=4'b1111.
- cmd drops to 0 while waiting on channel 1 in SHUTTING; ack arrives later -> chan_req goes 0011 -> 0001 -> 0000; final state UP; channels 2 and 3 are never requested.
- Acks tied to chan_req with zero delay -> one req transition per cycle; full shutdown completes within 4 cycles of cmd being sampled.
- Assert rst mid-SHUTTING with chan_req=0011 -> next cycle chan_req=0, status_up=1, err_mask=0, cur_chan=0.

Source files
------------

// File: rtl/axis_shutdown_sequencer.sv
// axis_shutdown_sequencer
// Orders shutdown (channel 0 first) and bring-up (channel N-1 first) of a
// chain of stream shutdown wrappers. Each channel step waits for the channel's
// acknowledge, bounded by a per-step timeout. Channels that time out are
// flagged in a sticky error mask until the next sequence starts from UP or DOWN.

module axis_shutdown_sequencer #(
  parameter int unsigned C_NUM_CHANNELS   = 4,
  parameter int unsigned C_TIMEOUT_CYCLES = 1024,
  parameter int unsigned C_TIMEOUT_WIDTH  = 16,
  localparam int unsigned IDX_W = (C_NUM_CHANNELS > 1) ? $clog2(C_NUM_CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_shutdown,
  output logic [C_NUM_CHANNELS-1:0] chan_req,
  input  logic [C_NUM_CHANNELS-1:0] chan_ack,
  output logic                      status_up,
  output logic                      status_down,
  output logic                      busy,
  output logic [IDX_W-1:0]          cur_chan,
  output logic [C_NUM_CHANNELS-1:0] err_mask
);

  typedef enum logic [1:0] {
    ST_UP       = 2'd0,
    ST_SHUTTING = 2'd1,
    ST_DOWN     = 2'd2,
    ST_STARTING = 2'd3
  } state_t;

  // Index of the most downstream channel.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_CHANNELS - 32'd1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(32'd1);
  localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(32'd0);

  // A zero timeout disables the step bound entirely.
  localparam bit TIMEOUT_EN = (C_TIMEOUT_CYCLES != 32'd0);

  // Counter value on the last allowed cycle of a step.
  localparam logic [C_TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
    C_TIMEOUT_WIDTH'(TIMEOUT_EN ? (C_TIMEOUT_CYCLES - 32'd1) : 32'd0);

  localparam logic [C_TIMEOUT_WIDTH-1:0] CNT_ONE  = C_TIMEOUT_WIDTH'(32'd1);
  localparam logic [C_TIMEOUT_WIDTH-1:0] CNT_ZERO = C_TIMEOUT_WIDTH'(32'd0);

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [C_TIMEOUT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [C_NUM_CHANNELS-1:0]   req_q, req_d;
  logic [C_NUM_CHANNELS-1:0]   err_q, err_d;
  logic                        status_up_q, status_up_d;
  logic                        status_down_q, status_down_d;
  logic                        busy_q, busy_d;

  logic                        ack_cur_s;
  logic                        timeout_hit_s;
  logic                        step_done_s;
  logic [IDX_W-1:0]            idx_next_s;
  logic [IDX_W-1:0]            idx_prev_s;
  logic                        cnt_at_last_s;

  // Next-state, channel request and step counter computation for the sequencer.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    err_d         = err_q;
    ack_cur_s     = chan_ack[idx_q];
    idx_next_s    = idx_q + ONE_IDX;
    idx_prev_s    = idx_q - ONE_IDX;
    cnt_at_last_s = TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);
    timeout_hit_s = 1'b0;
    step_done_s   = 1'b0;

    case (state_q)
      ST_UP: begin
        cnt_d = CNT_ZERO;
        if (cmd_shutdown) begin
          // Start a fresh shutdown from the most upstream channel.
          idx_d    = ZERO_IDX;
          err_d    = '0;
          req_d[0] = 1'b1;
          state_d  = ST_SHUTTING;
        end else begin
          state_d = ST_UP;
        end
      end

      ST_SHUTTING: begin
        timeout_hit_s = cnt_at_last_s && !ack_cur_s;
        step_done_s   = ack_cur_s || timeout_hit_s;
        if (step_done_s) begin
          cnt_d = CNT_ZERO;
          if (timeout_hit_s) begin
            err_d[idx_q] = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (!cmd_shutdown) begin
            // Reverse in place: release the channel just requested.
            req_d[idx_q] = 1'b0;
            state_d      = ST_STARTING;
          end else if (idx_q == LAST_IDX) begin
            state_d = ST_DOWN;
          end else begin
            idx_d             = idx_next_s;
            req_d[idx_next_s] = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DOWN: begin
        cnt_d = CNT_ZERO;
        if (!cmd_shutdown) begin
          // Bring-up starts at the most downstream channel.
          idx_d           = LAST_IDX;
          err_d           = '0;
          req_d[LAST_IDX] = 1'b0;
          state_d         = ST_STARTING;
        end else begin
          state_d = ST_DOWN;
        end
      end

      ST_STARTING: begin
        timeout_hit_s = cnt_at_last_s && ack_cur_s;
        step_done_s   = !ack_cur_s || timeout_hit_s;
        if (step_done_s) begin
          cnt_d = CNT_ZERO;
          if (timeout_hit_s) begin
            err_d[idx_q] = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (cmd_shutdown) begin
            // Reverse in place: re-request the channel just released.
            req_d[idx_q] = 1'b1;
            state_d      = ST_SHUTTING;
          end else if (idx_q == ZERO_IDX) begin
            state_d = ST_UP;
          end else begin
            idx_d             = idx_prev_s;
            req_d[idx_prev_s] = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        // Unreachable encoding: recover to the reset condition.
        state_d = ST_UP;
        idx_d   = ZERO_IDX;
        cnt_d   = CNT_ZERO;
        req_d   = '0;
        err_d   = '0;
      end
    endcase

    status_up_d   = (state_d == ST_UP);
    status_down_d = (state_d == ST_DOWN);
    busy_d        = (state_d == ST_SHUTTING) || (state_d == ST_STARTING);
  end

  // Sequencer state and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_UP;
      idx_q         <= ZERO_IDX;
      cnt_q         <= CNT_ZERO;
      req_q         <= '0;
      err_q         <= '0;
      status_up_q   <= 1'b1;
      status_down_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      err_q         <= err_d;
      status_up_q   <= status_up_d;
      status_down_q <= status_down_d;
      busy_q        <= busy_d;
    end
  end

  // A single channel has only index 0, so the index output is a constant.
  generate
    if (C_NUM_CHANNELS == 1) begin : g_single
      assign cur_chan = ZERO_IDX;
    end else begin : g_multi
      assign cur_chan = idx_q;
    end
  endgenerate

  assign chan_req    = req_q;
  assign err_mask    = err_q;
  assign status_up   = status_up_q;
  assign status_down = status_down_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_axis_shutdown_sequencer.sv
// Directed testbench for axis_shutdown_sequencer (4 channels, 8-cycle timeout).
// Acks come either from a 3-stage delay of chan_req or straight from chan_req,
// and individual acks can be held low to force timeouts.

module tb_axis_shutdown_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_shutdown;
  logic [3:0] chan_req;
  logic [3:0] chan_ack;
  logic       status_up;
  logic       status_down;
  logic       busy;
  logic [1:0] cur_chan;
  logic [3:0] err_mask;

  logic [3:0] d1_r = 4'd0;
  logic [3:0] d2_r = 4'd0;
  logic [3:0] d3_r = 4'd0;
  logic       ack_zero;
  logic [3:0] stuck;
  logic [3:0] seen;

  int n_checks = 0;
  int n_errors = 0;

  axis_shutdown_sequencer #(
    .C_NUM_CHANNELS   (4),
    .C_TIMEOUT_CYCLES (8),
    .C_TIMEOUT_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_shutdown (cmd_shutdown),
    .chan_req     (chan_req),
    .chan_ack     (chan_ack),
    .status_up    (status_up),
    .status_down  (status_down),
    .busy         (busy),
    .cur_chan     (cur_chan),
    .err_mask     (err_mask)
  );

  always #5 clk = ~clk;

  // Ack model: each ack follows its req three clock edges later.
  always @(posedge clk) begin
    d1_r <= chan_req;
    d2_r <= d1_r;
    d3_r <= d2_r;
  end

  assign chan_ack = (ack_zero ? chan_req : d3_r) & ~stuck;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    cmd_shutdown = 1'b0;
    ack_zero     = 1'b0;
    stuck        = 4'b0000;
    seen         = 4'b0000;
    repeat (3) tick();

    // Reset state
    check_eq("rst_req",    32'(chan_req),    32'h0);
    check_eq("rst_up",     32'(status_up),   32'h1);
    check_eq("rst_down",   32'(status_down), 32'h0);
    check_eq("rst_busy",   32'(busy),        32'h0);
    check_eq("rst_chan",   32'(cur_chan),    32'h0);
    check_eq("rst_err",    32'(err_mask),    32'h0);
    rst = 1'b0;
    repeat (4) tick();
    check_eq("idle_up",    32'(status_up),   32'h1);

    // Shutdown with 3-cycle ack lag: one new req every 4 cycles
    cmd_shutdown = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_eq("t1_req", 32'(chan_req), (32'd1 << (1 + (k - 1) / 4)) - 32'd1);
      if (k == 1) check_eq("t1_busy", 32'(busy), 32'h1);
      if (k == 10) check_eq("t1_chan", 32'(cur_chan), 32'h2);
    end
    tick();
    check_eq("t1_down",  32'(status_down), 32'h1);
    check_eq("t1_busy0", 32'(busy),        32'h0);
    check_eq("t1_up0",   32'(status_up),   32'h0);
    check_eq("t1_err",   32'(err_mask),    32'h0);
    check_eq("t1_reqf",  32'(chan_req),    32'hF);
    check_eq("t1_chan3", 32'(cur_chan),    32'h3);

    // Bring-up with 3-cycle ack lag: reqs fall 3,2,1,0
    cmd_shutdown = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_eq("t2_req", 32'(chan_req), (32'd1 << (3 - (k - 1) / 4)) - 32'd1);
    end
    tick();
    check_eq("t2_up",   32'(status_up), 32'h1);
    check_eq("t2_busy", 32'(busy),      32'h0);
    check_eq("t2_chan", 32'(cur_chan),  32'h0);
    check_eq("t2_req0", 32'(chan_req),  32'h0);

    // Channel 2 never acks: step 2 times out after exactly 8 cycles
    stuck        = 4'b0100;
    cmd_shutdown = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k <= 4)       check_eq("t3_req", 32'(chan_req), 32'h1);
      else if (k <= 8)  check_eq("t3_req", 32'(chan_req), 32'h3);
      else if (k <= 16) check_eq("t3_req", 32'(chan_req), 32'h7);
      else              check_eq("t3_req", 32'(chan_req), 32'hF);
      if (k == 16) check_eq("t3_err_pre",  32'(err_mask), 32'h0);
      if (k == 17) check_eq("t3_err_post", 32'(err_mask), 32'h4);
    end
    tick();
    check_eq("t3_down", 32'(status_down), 32'h1);
    check_eq("t3_reqf", 32'(chan_req),    32'hF);
    check_eq("t3_err",  32'(err_mask),    32'h4);

    rst          = 1'b1;
    cmd_shutdown = 1'b0;
    stuck        = 4'b0000;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check_eq("t3_rst_err", 32'(err_mask), 32'h0);

    // cmd drops while waiting on channel 1: reverse without touching 2 and 3
    cmd_shutdown = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      seen = seen | chan_req;
      if (k == 6) cmd_shutdown = 1'b0;
      if (k <= 4)       check_eq("t4_req", 32'(chan_req), 32'h1);
      else if (k <= 8)  check_eq("t4_req", 32'(chan_req), 32'h3);
      else if (k <= 12) check_eq("t4_req", 32'(chan_req), 32'h1);
      else              check_eq("t4_req", 32'(chan_req), 32'h0);
      if (k == 9) check_eq("t4_chan", 32'(cur_chan), 32'h1);
      if (k == 9) check_eq("t4_busy", 32'(busy),     32'h1);
    end
    tick();
    check_eq("t4_up",   32'(status_up),  32'h1);
    check_eq("t4_seen", 32'(seen[3:2]),  32'h0);
    check_eq("t4_err",  32'(err_mask),   32'h0);

    // Zero-delay acks: one req transition per cycle in both directions
    ack_zero     = 1'b1;
    cmd_shutdown = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq("t5_sreq", 32'(chan_req), (32'd1 << k) - 32'd1);
    end
    tick();
    check_eq("t5_down", 32'(status_down), 32'h1);
    cmd_shutdown = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq("t5_ureq", 32'(chan_req), (32'd1 << (4 - k)) - 32'd1);
    end
    tick();
    check_eq("t5_up", 32'(status_up), 32'h1);
    ack_zero = 1'b0;
    repeat (4) tick();

    // Reset mid-shutdown with chan_req = 0011 and a timeout flag set
    stuck        = 4'b0001;
    cmd_shutdown = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k <= 8) check_eq("t6_req", 32'(chan_req), 32'h1);
      else        check_eq("t6_req", 32'(chan_req), 32'h3);
      if (k == 8) check_eq("t6_err_pre", 32'(err_mask), 32'h0);
    end
    check_eq("t6_err",  32'(err_mask), 32'h1);
    check_eq("t6_chan", 32'(cur_chan), 32'h1);
    rst          = 1'b1;
    cmd_shutdown = 1'b0;
    tick();
    check_eq("t6_rst_req",  32'(chan_req),    32'h0);
    check_eq("t6_rst_up",   32'(status_up),   32'h1);
    check_eq("t6_rst_down", 32'(status_down), 32'h0);
    check_eq("t6_rst_busy", 32'(busy),        32'h0);
    check_eq("t6_rst_err",  32'(err_mask),    32'h0);
    check_eq("t6_rst_chan", 32'(cur_chan),    32'h0);
    rst   = 1'b0;
    stuck = 4'b0000;
    tick();
    check_eq("t6_post_up",  32'(status_up), 32'h1);
    check_eq("t6_post_req", 32'(chan_req),  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
